// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//
// Control FSM for a small multicycle RISC-V style datapath. It walks every
// instruction through fetch, IR load and decode, then through a short
// class-specific tail (R-type, I-type add, load, store, branch). Any unknown
// encoding parks the FSM in TRAP with the `illegal` flag set until reset.
//
// Parameters
//   MEM_LAT   memory read latency in cycles (legal 1..3). It sets how long the
//             FSM waits in FETCH and in LD_WAIT.
//
// Optional feature (compile-time macro)
//   BRANCH_BNE_EN  when defined, opcode 1100011 with funct3=001 (bne) goes to
//                  BRANCH and takes the branch when alu_zero is 0. When it is
//                  not defined, that encoding traps.
//
// Ports
//   clk, rst            rising-edge clock, synchronous active-high reset
//   opcode/funct3/funct7b5  instruction fields from the instruction register
//   alu_zero            ALU result-equals-zero flag (used in BRANCH)
//   PCwrite .. MemData_Wr   load/write strobes to the datapath
//   SelMux2             ALU A select (0 PC, 1 RegA)
//   SelMux4             ALU B select (00 RegB, 01 const 4, 10 imm, 11 shifted imm)
//   SelMuxMem           register write-data select (0 AluOut, 1 MemDataReg)
//   SelPC               PC source (0 ALU result, 1 AluOut register)
//   AluOperation        001 add, 010 sub, 011 and, 110 xor, 000 idle
//   State               current state code (debug/observation)
//   instr_done          one-cycle retire pulse
//   illegal             trap flag, held until reset
//
// Outputs are a decode of the state register. The only exceptions are PCwrite
// in BRANCH, which follows alu_zero in the same cycle, and R_EXEC, whose ALU
// operation comes from funct3/funct7b5. While rst is high every strobe is
// forced low and AluOperation is 000.
// -----------------------------------------------------------------------------
module multicycle_ctrl #(
  parameter int MEM_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       alu_zero,
  output logic       PCwrite,
  output logic       IRwrite,
  output logic       RegWrite,
  output logic       loadRegA,
  output logic       loadRegB,
  output logic       loadRegAluOut,
  output logic       loadRegMemData,
  output logic       MemData_Wr,
  output logic       SelMux2,
  output logic [1:0] SelMux4,
  output logic       SelMuxMem,
  output logic       SelPC,
  output logic [2:0] AluOperation,
  output logic [3:0] State,
  output logic       instr_done,
  output logic       illegal
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_IR_LOAD  = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_LD_WAIT  = 4'd4,
    S_LD_CAP   = 4'd5,
    S_LD_WB    = 4'd6,
    S_ST_WR    = 4'd7,
    S_R_EXEC   = 4'd8,
    S_I_EXEC   = 4'd9,
    S_ALU_WB   = 4'd10,
    S_BRANCH   = 4'd11,
    S_TRAP     = 4'd15
  } state_t;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_SD = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  localparam logic [2:0] ALU_IDLE = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b110;

  // The wait counter runs from 0 to MEM_LAT-1. A state that waits on memory
  // leaves on the cycle in which the counter reaches its last value.
  localparam logic [1:0] WAIT_LAST = 2'(MEM_LAT - 1);

  state_t     r_state;
  logic [1:0] r_wait_cnt;
  logic       r_illegal;

  logic       w_wait_done;
  logic       w_is_r;
  logic       w_is_i;
  logic       w_is_ld;
  logic       w_is_sd;
  logic       w_is_bne;
  logic       w_is_br;
  logic       w_r_legal;
  logic [2:0] w_r_aluop;
  logic       w_br_take;

  assign w_wait_done = (r_wait_cnt == WAIT_LAST);

  // Dispatch qualifiers. They are evaluated against the live IR fields, which
  // stay stable for the whole instruction.
  assign w_is_r  = (opcode == OP_R);
  assign w_is_i  = (opcode == OP_I)  && (funct3 == 3'b000);
  assign w_is_ld = (opcode == OP_LD) && (funct3 == 3'b011);
  assign w_is_sd = (opcode == OP_SD) && (funct3 == 3'b111);

`ifdef BRANCH_BNE_EN
  assign w_is_bne  = (opcode == OP_BR) && (funct3 == 3'b001);
  assign w_br_take = (funct3 == 3'b001) ? !alu_zero : alu_zero;
`else
  assign w_is_bne  = 1'b0;
  assign w_br_take = alu_zero;
`endif

  assign w_is_br = ((opcode == OP_BR) && (funct3 == 3'b000)) || w_is_bne;

  // R-type ALU selection. funct7b5 only separates add from sub.
  always_comb begin
    w_r_legal = 1'b1;
    w_r_aluop = ALU_IDLE;
    case (funct3)
      3'b000:  w_r_aluop = funct7b5 ? ALU_SUB : ALU_ADD;
      3'b111:  w_r_aluop = ALU_AND;
      3'b100:  w_r_aluop = ALU_XOR;
      default: w_r_legal = 1'b0;
    endcase
  end

  // State, wait counter and trap flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_FETCH;
      r_wait_cnt <= 2'd0;
      r_illegal  <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (w_wait_done) begin
            r_state    <= S_IR_LOAD;
            r_wait_cnt <= 2'd0;
          end else begin
            r_wait_cnt <= r_wait_cnt + 2'd1;
          end
        end
        S_IR_LOAD: r_state <= S_DECODE;
        S_DECODE: begin
          if (w_is_r) begin
            r_state <= S_R_EXEC;
          end else if (w_is_i) begin
            r_state <= S_I_EXEC;
          end else if (w_is_ld || w_is_sd) begin
            r_state <= S_MEM_ADDR;
          end else if (w_is_br) begin
            r_state <= S_BRANCH;
          end else begin
            r_state   <= S_TRAP;
            r_illegal <= 1'b1;
          end
        end
        S_MEM_ADDR: r_state <= (opcode == OP_LD) ? S_LD_WAIT : S_ST_WR;
        S_LD_WAIT: begin
          if (w_wait_done) begin
            r_state    <= S_LD_CAP;
            r_wait_cnt <= 2'd0;
          end else begin
            r_wait_cnt <= r_wait_cnt + 2'd1;
          end
        end
        S_LD_CAP: r_state <= S_LD_WB;
        S_LD_WB:  r_state <= S_FETCH;
        S_ST_WR:  r_state <= S_FETCH;
        S_R_EXEC: begin
          if (w_r_legal) begin
            r_state <= S_ALU_WB;
          end else begin
            r_state   <= S_TRAP;
            r_illegal <= 1'b1;
          end
        end
        S_I_EXEC: r_state <= S_ALU_WB;
        S_ALU_WB: r_state <= S_FETCH;
        S_BRANCH: r_state <= S_FETCH;
        S_TRAP:   r_state <= S_TRAP;
        // Unused codes 12..14 can only come from an upset. Treat them as a trap.
        default: begin
          r_state   <= S_TRAP;
          r_illegal <= 1'b1;
        end
      endcase
    end
  end

  assign State   = r_state;
  assign illegal = r_illegal;

  // Output decode. Everything defaults low, and while rst is high it stays low.
  always_comb begin
    PCwrite        = 1'b0;
    IRwrite        = 1'b0;
    RegWrite       = 1'b0;
    loadRegA       = 1'b0;
    loadRegB       = 1'b0;
    loadRegAluOut  = 1'b0;
    loadRegMemData = 1'b0;
    MemData_Wr     = 1'b0;
    SelMux2        = 1'b0;
    SelMux4        = 2'b00;
    SelMuxMem      = 1'b0;
    SelPC          = 1'b0;
    AluOperation   = ALU_IDLE;
    instr_done     = 1'b0;
    if (!rst) begin
      case (r_state)
        S_IR_LOAD: begin
          // PC <= PC + 4 while the IR captures the fetched word.
          IRwrite      = 1'b1;
          PCwrite      = 1'b1;
          SelMux4      = 2'b01;
          AluOperation = ALU_ADD;
        end
        S_DECODE: begin
          // The branch target is computed speculatively into AluOut.
          loadRegA      = 1'b1;
          loadRegB      = 1'b1;
          loadRegAluOut = 1'b1;
          SelMux4       = 2'b11;
          AluOperation  = ALU_ADD;
        end
        S_MEM_ADDR, S_I_EXEC: begin
          SelMux2       = 1'b1;
          SelMux4       = 2'b10;
          AluOperation  = ALU_ADD;
          loadRegAluOut = 1'b1;
        end
        S_R_EXEC: begin
          // An unsupported funct3 issues nothing and traps on the next edge.
          if (w_r_legal) begin
            SelMux2       = 1'b1;
            loadRegAluOut = 1'b1;
            AluOperation  = w_r_aluop;
          end
        end
        S_ALU_WB: begin
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
        S_LD_CAP: loadRegMemData = 1'b1;
        S_LD_WB: begin
          RegWrite   = 1'b1;
          SelMuxMem  = 1'b1;
          instr_done = 1'b1;
        end
        S_ST_WR: begin
          MemData_Wr = 1'b1;
          instr_done = 1'b1;
        end
        S_BRANCH: begin
          // Compare RegA - RegB. When the branch is taken, the PC loads the
          // target that was already captured in AluOut during DECODE.
          SelMux2      = 1'b1;
          AluOperation = ALU_SUB;
          PCwrite      = w_br_take;
          SelPC        = 1'b1;
          instr_done   = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
`timescale 1ns/1ps
module tb_multicycle_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst1 = 1'b1;
  logic       rst2 = 1'b1;
  logic [6:0] opcode = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       funct7b5 = 1'b0;
  logic       alu_zero = 1'b0;

`ifdef BRANCH_BNE_EN
  localparam bit BNE_EN = 1'b1;
`else
  localparam bit BNE_EN = 1'b0;
`endif

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_SD = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  localparam logic [7:0] P_PCW = 8'h80;
  localparam logic [7:0] P_IRW = 8'h40;
  localparam logic [7:0] P_RW  = 8'h20;
  localparam logic [7:0] P_LA  = 8'h10;
  localparam logic [7:0] P_LB  = 8'h08;
  localparam logic [7:0] P_LAO = 8'h04;
  localparam logic [7:0] P_LMD = 8'h02;
  localparam logic [7:0] P_MW  = 8'h01;

  localparam logic [2:0] A_NONE = 3'b000;
  localparam logic [2:0] A_ADD  = 3'b001;
  localparam logic [2:0] A_SUB  = 3'b010;
  localparam logic [2:0] A_AND  = 3'b011;
  localparam logic [2:0] A_XOR  = 3'b110;

  // ---------------- DUTs: MEM_LAT=1 and MEM_LAT=2 ----------------
  logic       pcw1, irw1, rw1, la1, lb1, lao1, lmd1, mw1, m2_1, mm1, spc1, done1, ill1;
  logic [1:0] m4_1;
  logic [2:0] aop1;
  logic [3:0] st1;
  logic       pcw2, irw2, rw2, la2, lb2, lao2, lmd2, mw2, m2_2, mm2, spc2, done2, ill2;
  logic [1:0] m4_2;
  logic [2:0] aop2;
  logic [3:0] st2;

  multicycle_ctrl #(.MEM_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst1), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
    .alu_zero(alu_zero), .PCwrite(pcw1), .IRwrite(irw1), .RegWrite(rw1),
    .loadRegA(la1), .loadRegB(lb1), .loadRegAluOut(lao1), .loadRegMemData(lmd1),
    .MemData_Wr(mw1), .SelMux2(m2_1), .SelMux4(m4_1), .SelMuxMem(mm1), .SelPC(spc1),
    .AluOperation(aop1), .State(st1), .instr_done(done1), .illegal(ill1)
  );

  multicycle_ctrl #(.MEM_LAT(2)) u_dut2 (
    .clk(clk), .rst(rst2), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
    .alu_zero(alu_zero), .PCwrite(pcw2), .IRwrite(irw2), .RegWrite(rw2),
    .loadRegA(la2), .loadRegB(lb2), .loadRegAluOut(lao2), .loadRegMemData(lmd2),
    .MemData_Wr(mw2), .SelMux2(m2_2), .SelMux4(m4_2), .SelMuxMem(mm2), .SelPC(spc2),
    .AluOperation(aop2), .State(st2), .instr_done(done2), .illegal(ill2)
  );

  logic [21:0] obs1, obs2, obs;
  assign obs1 = {st1, pcw1, irw1, rw1, la1, lb1, lao1, lmd1, mw1, m2_1, m4_1, mm1, spc1, aop1, done1, ill1};
  assign obs2 = {st2, pcw2, irw2, rw2, la2, lb2, lao2, lmd2, mw2, m2_2, m4_2, mm2, spc2, aop2, done2, ill2};

  int sel = 1;  // which DUT is under test
  int lat = 1;  // its MEM_LAT
  assign obs = (sel == 1) ? obs1 : obs2;

  // ---------------- scoreboard ----------------
  typedef struct {
    string nm;
    int    got;
    int    exp;
  } lit_t;

  logic [21:0] exp_q[$];
  string       name_q[$];
  lit_t        lit_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_done  = 0;
  int last_done = 0;
  int last_br_pcw = -1;

  logic [21:0] cmp_e;
  string       cmp_nm;
  lit_t        cmp_l;

  // Single compare process: one expected word per cycle, plus literal checks.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (obs[1]) begin
      n_done    = n_done + 1;
      last_done = cyc;
    end
    if (obs[21:18] == 4'd11) last_br_pcw = int'(obs[17]);
    if (exp_q.size() != 0) begin
      cmp_e  = exp_q.pop_front();
      cmp_nm = name_q.pop_front();
      n_tests = n_tests + 1;
      if (obs !== cmp_e) begin
        n_fail = n_fail + 1;
        $display("FAIL %s got=%h exp=%h (st %0d vs %0d)", cmp_nm, obs, cmp_e, obs[21:18], cmp_e[21:18]);
      end
    end
    while (lit_q.size() != 0) begin
      cmp_l = lit_q.pop_front();
      n_tests = n_tests + 1;
      if (cmp_l.got != cmp_l.exp) begin
        n_fail = n_fail + 1;
        $display("FAIL %s got=%0d exp=%0d", cmp_l.nm, cmp_l.got, cmp_l.exp);
      end
    end
  end

  // ---------------- model helpers ----------------
  function automatic logic [21:0] mk(input logic [3:0] st, input logic [7:0] stb, input logic m2,
                                     input logic [1:0] m4, input logic mm, input logic spc,
                                     input logic [2:0] aop, input logic done, input logic ill);
    return {st, stb, m2, m4, mm, spc, aop, done, ill};
  endfunction

  task automatic push(input logic [21:0] w, input string nm);
    exp_q.push_back(w);
    name_q.push_back(nm);
  endtask

  task automatic lit(input string nm, input int got, input int exp);
    lit_t t;
    t.nm = nm;
    t.got = got;
    t.exp = exp;
    lit_q.push_back(t);
  endtask

  // Waits until every queued expectation is consumed; returns at posedge+1.
  task automatic drain(input string nm);
    int g;
    g = 0;
    while ((exp_q.size() != 0 || lit_q.size() != 0) && g < 200) begin
      @(posedge clk);
      g++;
    end
    if (g >= 200) begin
      exp_q.delete();
      name_q.delete();
      lit({nm, "_timeout"}, 1, 0);
    end
    #1;
  endtask

  // Fetch (lat cycles), IR_LOAD, DECODE: common to every instruction.
  task automatic push_front_end(input string nm);
    for (int i = 0; i < lat; i++) push(mk(4'd0, 8'h00, 1'b0, 2'b00, 1'b0, 1'b0, A_NONE, 1'b0, 1'b0), {nm, "_fetch"});
    push(mk(4'd1, P_PCW | P_IRW, 1'b0, 2'b01, 1'b0, 1'b0, A_ADD, 1'b0, 1'b0), {nm, "_irload"});
    push(mk(4'd2, P_LA | P_LB | P_LAO, 1'b0, 2'b11, 1'b0, 1'b0, A_ADD, 1'b0, 1'b0), {nm, "_decode"});
  endtask

  // Drives one instruction and queues its whole expected trace. exp_lat is
  // the hand-computed retire cycle, or -1 for an instruction that traps.
  task automatic run_instr(input string nm, input logic [6:0] opc, input logic [2:0] f3,
                           input logic b5, input logic z, input int exp_lat);
    logic [2:0] aop;
    bit trap;
    bit take;
    int c0;
    int d0;
    trap = 1'b0;
    opcode = opc;
    funct3 = f3;
    funct7b5 = b5;
    alu_zero = z;
    c0 = cyc;
    d0 = n_done;
    push_front_end(nm);
    if (opc == OP_R) begin
      if (f3 == 3'b000 || f3 == 3'b111 || f3 == 3'b100) begin
        aop = (f3 == 3'b111) ? A_AND : (f3 == 3'b100) ? A_XOR : (b5 ? A_SUB : A_ADD);
        push(mk(4'd8, P_LAO, 1'b1, 2'b00, 1'b0, 1'b0, aop, 1'b0, 1'b0), {nm, "_rexec"});
        push(mk(4'd10, P_RW, 1'b0, 2'b00, 1'b0, 1'b0, A_NONE, 1'b1, 1'b0), {nm, "_alu_wb"});
      end else begin
        push(mk(4'd8, 8'h00, 1'b0, 2'b00, 1'b0, 1'b0, A_NONE, 1'b0, 1'b0), {nm, "_rexec_bad"});
        trap = 1'b1;
      end
    end else if (opc == OP_I && f3 == 3'b000) begin
      push(mk(4'd9, P_LAO, 1'b1, 2'b10, 1'b0, 1'b0, A_ADD, 1'b0, 1'b0), {nm, "_iexec"});
      push(mk(4'd10, P_RW, 1'b0, 2'b00, 1'b0, 1'b0, A_NONE, 1'b1, 1'b0), {nm, "_alu_wb"});
    end else if ((opc == OP_LD && f3 == 3'b011) || (opc == OP_SD && f3 == 3'b111)) begin
      push(mk(4'd3, P_LAO, 1'b1, 2'b10, 1'b0, 1'b0, A_ADD, 1'b0, 1'b0), {nm, "_memaddr"});
      if (opc == OP_LD) begin
        for (int i = 0; i < lat; i++) push(mk(4'd4, 8'h00, 1'b0, 2'b00, 1'b0, 1'b0, A_NONE, 1'b0, 1'b0), {nm, "_ldwait"});
        push(mk(4'd5, P_LMD, 1'b0, 2'b00, 1'b0, 1'b0, A_NONE, 1'b0, 1'b0), {nm, "_ldcap"});
        push(mk(4'd6, P_RW, 1'b0, 2'b00, 1'b1, 1'b0, A_NONE, 1'b1, 1'b0), {nm, "_ldwb"});
      end else begin
        push(mk(4'd7, P_MW, 1'b0, 2'b00, 1'b0, 1'b0, A_NONE, 1'b1, 1'b0), {nm, "_stwr"});
      end
    end else if (opc == OP_BR && (f3 == 3'b000 || (BNE_EN && f3 == 3'b001))) begin
      take = (f3 == 3'b000) ? z : !z;
      push(mk(4'd11, take ? P_PCW : 8'h00, 1'b1, 2'b00, 1'b0, 1'b1, A_SUB, 1'b1, 1'b0), {nm, "_branch"});
    end else begin
      trap = 1'b1;
    end
    if (trap) begin
      for (int i = 0; i < 10; i++) push(mk(4'd15, 8'h00, 1'b0, 2'b00, 1'b0, 1'b0, A_NONE, 1'b0, 1'b1), {nm, "_trap"});
    end
    drain(nm);
    if (exp_lat < 0) begin
      lit({nm, "_ndone"}, n_done - d0, 0);
    end else begin
      lit({nm, "_latency"}, last_done - c0, exp_lat);
      lit({nm, "_ndone"}, n_done - d0, 1);
    end
  endtask

  // Synchronous reset of the DUT under test. Optionally checks the cycle in
  // which rst is high but the edge has not yet happened.
  task automatic do_reset(input bit chk_during, input logic [21:0] during_w);
    if (sel == 1) rst1 = 1'b1;
    else rst2 = 1'b1;
    if (chk_during) push(during_w, "rst_during");
    @(posedge clk);
    #1;
    push(mk(4'd0, 8'h00, 1'b0, 2'b00, 1'b0, 1'b0, A_NONE, 1'b0, 1'b0), "rst_state");
    @(posedge clk);
    #1;
    if (sel == 1) rst1 = 1'b0;
    else rst2 = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    @(posedge clk);
    #1;
    do_reset(1'b0, 22'd0);

    // MEM_LAT = 1
    run_instr("add",  OP_R,  3'b000, 1'b0, 1'b0, 5);
    run_instr("sub",  OP_R,  3'b000, 1'b1, 1'b0, 5);
    run_instr("and",  OP_R,  3'b111, 1'b1, 1'b0, 5);
    run_instr("xor",  OP_R,  3'b100, 1'b0, 1'b0, 5);
    run_instr("addi", OP_I,  3'b000, 1'b0, 1'b0, 5);
    run_instr("ld",   OP_LD, 3'b011, 1'b0, 1'b0, 7);
    run_instr("sd",   OP_SD, 3'b111, 1'b0, 1'b0, 5);
    run_instr("beq_t", OP_BR, 3'b000, 1'b0, 1'b1, 4);
    lit("beq_t_pcwrite", last_br_pcw, 1);
    run_instr("beq_nt", OP_BR, 3'b000, 1'b0, 1'b0, 4);
    lit("beq_nt_pcwrite", last_br_pcw, 0);
    run_instr("bne", OP_BR, 3'b001, 1'b0, 1'b0, BNE_EN ? 4 : -1);
    do_reset(1'b0, 22'd0);
    run_instr("r_badf3", OP_R, 3'b010, 1'b0, 1'b0, -1);
    do_reset(1'b1, mk(4'd15, 8'h00, 1'b0, 2'b00, 1'b0, 1'b0, A_NONE, 1'b0, 1'b1));
    run_instr("ld_badf3", OP_LD, 3'b010, 1'b0, 1'b0, -1);
    do_reset(1'b0, 22'd0);
    run_instr("op_ones", 7'b1111111, 3'b000, 1'b0, 1'b0, -1);
    do_reset(1'b1, mk(4'd15, 8'h00, 1'b0, 2'b00, 1'b0, 1'b0, A_NONE, 1'b0, 1'b1));
    run_instr("addi_after_trap", OP_I, 3'b000, 1'b0, 1'b0, 5);

    // Switch to the MEM_LAT = 2 instance.
    rst1 = 1'b1;
    sel = 2;
    lat = 2;
    do_reset(1'b0, 22'd0);
    run_instr("add_l2", OP_R,  3'b000, 1'b0, 1'b0, 6);
    run_instr("ld_l2",  OP_LD, 3'b011, 1'b0, 1'b0, 9);
    run_instr("sd_l2",  OP_SD, 3'b111, 1'b0, 1'b0, 6);

    // Load interrupted by reset in its second LD_WAIT cycle.
    opcode = OP_LD;
    funct3 = 3'b011;
    push_front_end("ld_rst");
    push(mk(4'd3, P_LAO, 1'b1, 2'b10, 1'b0, 1'b0, A_ADD, 1'b0, 1'b0), "ld_rst_memaddr");
    push(mk(4'd4, 8'h00, 1'b0, 2'b00, 1'b0, 1'b0, A_NONE, 1'b0, 1'b0), "ld_rst_ldwait");
    drain("ld_rst");
    do_reset(1'b1, mk(4'd4, 8'h00, 1'b0, 2'b00, 1'b0, 1'b0, A_NONE, 1'b0, 1'b0));
    run_instr("addi_l2", OP_I, 3'b000, 1'b0, 1'b0, 6);

    push(mk(4'd0, 8'h00, 1'b0, 2'b00, 1'b0, 1'b0, A_NONE, 1'b0, 1'b0), "final_fetch");
    drain("final");
    @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter MEM_LAT, default 1, memory read latency in cycles, legal range 1..3.
REQ-002 SHALL have port clk  in  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-004 SHALL have port opcode  in  7  instruction bits 6:0 from the instruction register.
REQ-005 SHALL have port funct3  in  3  instruction bits 14:12.
REQ-006 SHALL have port funct7b5  in  1  instruction bit 30.
REQ-007 SHALL have port alu_zero  in  1  ALU result-equals-zero flag.
REQ-008 SHALL have ports PCwrite, IRwrite, RegWrite, loadRegA, loadRegB, loadRegAluOut, loadRegMemData, MemData_Wr  out  1 each  load/write strobes to the datapath.
REQ-009 SHALL have port SelMux2  out  1  ALU A select: 0 = PC, 1 = RegA.
REQ-010 SHALL have port SelMux4  out  2  ALU B select: 00 = RegB, 01 = constant 4, 10 = sign-extended imm, 11 = shifted imm.
REQ-011 SHALL have port SelMuxMem  out  1  register write-data select: 0 = AluOut, 1 = MemDataReg.
REQ-012 SHALL have port SelPC  out  1  PC source: 0 = ALU result, 1 = AluOut register.
REQ-013 SHALL have port AluOperation  out  3  ALU opcode: 001 add, 010 sub, 011 and, 110 xor; 000 when idle.
REQ-014 SHALL have ports State  out  4  (current state code), instr_done  out  1  (one-cycle retire pulse), illegal  out  1  (trap flag).

Function
REQ-015 SHALL implement state codes FETCH=0, IR_LOAD=1, DECODE=2, MEM_ADDR=3, LD_WAIT=4, LD_CAP=5, LD_WB=6, ST_WR=7, R_EXEC=8, I_EXEC=9, ALU_WB=10, BRANCH=11, TRAP=15.
REQ-016 SHALL deassert every strobe not listed for a state; outputs are decoded from State, except PCwrite in BRANCH.
REQ-017 SHALL stay in FETCH for MEM_LAT cycles, timed by an internal wait counter, then go to IR_LOAD.
REQ-018 SHALL in IR_LOAD assert IRwrite, PCwrite, SelMux2=0, SelMux4=01 and add (PC <= PC+4), then go to DECODE.
REQ-019 SHALL in DECODE assert loadRegA, loadRegB, loadRegAluOut, SelMux2=0, SelMux4=11 and add (branch target into AluOut), then dispatch on opcode.
REQ-020 SHALL dispatch 0110011 to R_EXEC, 0010011 with funct3=000 to I_EXEC, 0000011 with funct3=011 or 0100011 with funct3=111 to MEM_ADDR, 1100011 with funct3=000 to BRANCH, and anything else to TRAP.
REQ-021 SHALL in R_EXEC select SelMux2=1, SelMux4=00, with funct3/funct7b5 000/0 add, 000/1 sub, 111/x and, 100/x xor, assert loadRegAluOut, and go to TRAP with no strobe for any other funct3.
REQ-022 SHALL in I_EXEC use SelMux2=1, SelMux4=10, add and loadRegAluOut; R_EXEC and I_EXEC then go to ALU_WB.
REQ-023 SHALL in ALU_WB assert RegWrite with SelMuxMem=0 and instr_done, then go to FETCH.
REQ-024 SHALL in MEM_ADDR use SelMux2=1, SelMux4=10, add and loadRegAluOut, then go to LD_WAIT for a load or ST_WR for a store.
REQ-025 SHALL hold LD_WAIT for MEM_LAT cycles, then in LD_CAP assert loadRegMemData, then in LD_WB assert RegWrite with SelMuxMem=1 and instr_done, then go to FETCH.
REQ-026 SHALL in ST_WR assert MemData_Wr and instr_done for exactly one cycle, then go to FETCH.
REQ-027 SHALL in BRANCH use SelMux2=1, SelMux4=00 and sub, assert PCwrite=alu_zero with SelPC=1 in the same cycle, assert instr_done, then go to FETCH.
REQ-028 SHALL in TRAP hold illegal=1 with all strobes 0 until rst.
REQ-029 SHALL take per-instruction latency with MEM_LAT=1 of: R/I 5 cycles, ld 7, sd 5, branch 4.

Reset
REQ-030 SHALL on rst=1 at a clock edge, in any state and mid-instruction, enter FETCH, clear the wait counter and clear illegal.
REQ-031 SHALL hold all strobes at 0 and AluOperation at 000 while rst is high; the first FETCH cycle follows the first edge with rst low.

Configuration
REQ-032 SHALL, when BRANCH_BNE_EN is defined, dispatch opcode 1100011 with funct3=001 to BRANCH with PCwrite=!alu_zero; when undefined, that encoding goes to TRAP.

Verification
REQ-033 SHALL cover add x3,x1,x2 (opcode 0110011, funct3 000, b5 0) -> States 0,1,2,8,10,0; RegWrite high in state 10 only; instr_done one pulse.
REQ-034 SHALL cover ld with MEM_LAT=2 -> FETCH lasts 2 cycles, LD_WAIT 2 cycles, loadRegMemData in LD_CAP, RegWrite with SelMuxMem=1 in LD_WB; 9 cycles total.
REQ-035 SHALL cover beq with alu_zero=1 then 0 -> PCwrite=1, SelPC=1 in BRANCH; next run PCwrite=0; both return to FETCH after 4 cycles.
REQ-036 SHALL cover opcode 1111111 -> TRAP, illegal=1, all strobes 0 for 10 cycles; rst pulse -> FETCH, illegal=0.
REQ-037 SHALL cover rst asserted during LD_WAIT -> FETCH next cycle, no RegWrite or loadRegMemData issued.
REQ-038 SHALL cover bne (funct3 001) with alu_zero=0 -> PC taken with BRANCH_BNE_EN defined; TRAP without it.
